// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 keystream XOR stream block.
// RC4_XOR_DROP_EN adds the DROP state that discards leading keystream bytes.
package rc4_pkg;

  localparam int KS_W = 8;

  typedef logic [KS_W-1:0] ks_byte_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
`ifdef RC4_XOR_DROP_EN
    DROP  = 3'd2,
`endif
    RUN   = 3'd3,
    DRAIN = 3'd4
  } rc4_state_e;

endpackage

// File: rtl/rc4_xor_stream_if.sv
// Byte stream handshake (valid/ready/data/last) used for both the host input
// and the XORed output of rc4_xor_stream.
interface rc4_xor_stream_if;
  import rc4_pkg::*;

  logic     valid;
  logic     ready;
  logic     last;
  ks_byte_t data;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);

endinterface

// File: rtl/rc4_ks_fifo.sv
// Keystream prefetch FIFO, FIFO_DEPTH x 8, power-of-two depth; the head is
// presented combinationally on dout and clr empties it in one cycle.
module rc4_ks_fifo
  import rc4_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clr,
  input  logic                        push,
  input  ks_byte_t                    din,
  input  logic                        pop,
  output ks_byte_t                    dout,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        empty,
  output logic                        full
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  ks_byte_t        mem [FIFO_DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic            push_ok;
  logic            pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(FIFO_DEPTH));
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/rc4_xor_stream.sv
// Consumer end of the RC4 keystream: starts the generator, prefetches bytes and
// XORs them onto the data stream. RC4_XOR_DROP_EN enables RC4-drop[DROP_N].
module rc4_xor_stream
  import rc4_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DROP_N     = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                gen_start,
  input  logic                gen_ready,
  output logic                ks_req,
  input  logic                ks_valid,
  input  ks_byte_t            ks_data,
  rc4_xor_stream_if.slave     in_if,
  rc4_xor_stream_if.master    out_if,
  output logic                ks_err
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  rc4_state_e     state, state_nxt;
  logic [CW-1:0]  outstanding;
  logic [CW-1:0]  fifo_count;
  ks_byte_t       fifo_head;
  logic           fifo_empty, fifo_full;
  logic           fifo_push, fifo_pop, fifo_clr;
  logic           last_seen;
  logic           out_valid_q, out_last_q;
  ks_byte_t       out_data_q;
  logic           in_ready, accept, ks_hit, out_free, room;

  // A response only counts against a request that is actually in flight.
  assign ks_hit   = ks_valid && (outstanding != '0);
  assign out_free = !out_valid_q || out_if.ready;
  assign room     = ({1'b0, outstanding} + {1'b0, fifo_count}) < (CW + 1)'(FIFO_DEPTH);

`ifdef RC4_XOR_DROP_EN
  localparam int DW = (DROP_N > 1) ? $clog2(DROP_N) : 1;
  logic [DW-1:0] drop_cnt;
  logic          drop_last;

  assign drop_last = (drop_cnt == DW'(DROP_N - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || fifo_clr) begin
      drop_cnt <= '0;
    end else if (state == DROP && ks_hit) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end
`else
  logic unused_drop_n;
  assign unused_drop_n = (DROP_N != 0);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    ks_req    = 1'b0;
    in_ready  = 1'b0;
    accept    = 1'b0;
    fifo_push = 1'b0;
    fifo_pop  = 1'b0;
    fifo_clr  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = INIT;
          fifo_clr  = 1'b1;
        end
      end
      INIT: begin
        if (gen_ready) begin
`ifdef RC4_XOR_DROP_EN
          state_nxt = DROP;
`else
          state_nxt = RUN;
`endif
        end
      end
`ifdef RC4_XOR_DROP_EN
      DROP: begin
        ks_req = room && !fifo_full && !last_seen;
        if (ks_hit && drop_last) state_nxt = RUN;
      end
`endif
      RUN: begin
        ks_req    = room && !fifo_full && !last_seen;
        in_ready  = !fifo_empty && out_free && !last_seen;
        accept    = in_ready && in_if.valid;
        fifo_pop  = accept;
        fifo_push = ks_hit;
        if (accept && in_if.last) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (outstanding == '0 && out_free) begin
          state_nxt = IDLE;
          fifo_clr  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gen_start   <= 1'b0;
      done        <= 1'b0;
      ks_err      <= 1'b0;
      outstanding <= '0;
      last_seen   <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      gen_start <= (state == IDLE) && start;
      done      <= (state == DRAIN) && (state_nxt == IDLE);
      if (ks_valid && outstanding == '0) ks_err <= 1'b1;
      if (fifo_clr) begin
        outstanding <= '0;
        last_seen   <= 1'b0;
      end else begin
        outstanding <= outstanding + CW'(ks_req) - CW'(ks_hit);
      end
      if (accept) begin
        out_valid_q <= 1'b1;
        out_data_q  <= in_if.data ^ fifo_head;
        out_last_q  <= in_if.last;
        if (in_if.last) last_seen <= 1'b1;
      end else if (out_if.ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign in_if.ready  = in_ready;
  assign out_if.valid = out_valid_q;
  assign out_if.data  = out_data_q;
  assign out_if.last  = out_last_q;

  rc4_ks_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (fifo_clr),
    .push  (fifo_push),
    .din   (ks_data),
    .pop   (fifo_pop),
    .dout  (fifo_head),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

endmodule

// File: tb/tb_rc4_xor_stream.sv
// Self-checking bench for rc4_xor_stream with a behavioural RC4 generator
// (key "Key", random 0-3 cycle response delay) and an output scoreboard.
module tb_rc4_xor_stream;
  import rc4_pkg::*;

  localparam int FIFO_DEPTH = 4;
`ifdef RC4_XOR_DROP_EN
  localparam int SKIP = 4;
`else
  localparam int SKIP = 0;
`endif

  typedef logic [7:0] q8_t[$];

  logic     clk = 1'b0;
  logic     rst_n = 1'b0;
  logic     start = 1'b0;
  logic     gen_ready = 1'b0;
  logic     m_valid = 1'b0;
  logic     spur_valid = 1'b0;
  ks_byte_t m_data = '0;
  logic     busy, done, gen_start, ks_req, ks_err, ks_valid;
  ks_byte_t ks_data;

  rc4_xor_stream_if in_if ();
  rc4_xor_stream_if out_if ();

  assign ks_valid = m_valid | spur_valid;
  assign ks_data  = spur_valid ? 8'hA5 : m_data;

  rc4_xor_stream #(.FIFO_DEPTH(FIFO_DEPTH), .DROP_N(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .gen_start (gen_start),
    .gen_ready (gen_ready),
    .ks_req    (ks_req),
    .ks_valid  (ks_valid),
    .ks_data   (ks_data),
    .in_if     (in_if),
    .out_if    (out_if),
    .ks_err    (ks_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural RC4 generator ----------------
  logic [23:0] key = 24'h4B6579;
  logic [7:0]  ms [256];
  int          mi, mj;
  logic [7:0]  ref_ks [32];

  task automatic m_ksa();
    logic [7:0] t;
    for (int i = 0; i < 256; i++) ms[i] = 8'(i);
    mj = 0;
    for (int i = 0; i < 256; i++) begin
      mj = (mj + int'(ms[i]) + int'(key[23 - 8*(i%3) -: 8])) & 255;
      t = ms[i]; ms[i] = ms[mj]; ms[mj] = t;
    end
    mi = 0;
    mj = 0;
  endtask

  task automatic m_prga(output logic [7:0] k);
    logic [7:0] t;
    mi = (mi + 1) & 255;
    mj = (mj + int'(ms[mi])) & 255;
    t = ms[mi]; ms[mi] = ms[mj]; ms[mj] = t;
    k = ms[(int'(ms[mi]) + int'(ms[mj])) & 255];
  endtask

  int cyc = 0;
  int ready_at = 0;
  int pend[$];
  int max_inflight = 0;

  always @(negedge clk) begin
    logic [7:0] kb;
    int due;
    cyc++;
    m_valid = 1'b0;
    if (!rst_n) begin
      pend.delete();
      gen_ready = 1'b0;
      ready_at = 0;
    end else begin
      if (gen_start) begin
        m_ksa();
        pend.delete();
        gen_ready = 1'b0;
        ready_at = cyc + 2 + int'($urandom_range(0, 3));
      end else if (done) begin
        gen_ready = 1'b0;
      end else if (!gen_ready && ready_at != 0 && cyc >= ready_at) begin
        gen_ready = 1'b1;
        ready_at = 0;
      end
      if (pend.size() > 0 && pend[0] <= cyc) begin
        void'(pend.pop_front());
        m_prga(kb);
        m_valid = 1'b1;
        m_data = kb;
      end
      if (ks_req) begin
        due = cyc + 1 + int'($urandom_range(0, 3));
        if (pend.size() > 0 && due <= pend[$]) due = pend[$] + 1;
        pend.push_back(due);
        if (pend.size() > max_inflight) max_inflight = pend.size();
      end
    end
  end

  // ---------------- output backpressure ----------------
  bit bp_mode = 1'b0;
  int bp_phase = 0;
  always begin
    if (bp_mode) begin
      out_if.ready = (bp_phase == 0);
      bp_phase = (bp_phase + 1) % 4;
    end else begin
      out_if.ready = 1'b1;
    end
    @(posedge clk);
    #1;
  end

  // ---------------- scoreboard monitor ----------------
  logic [8:0] sb[$];
  int         gs_cnt = 0;
  logic       prev_valid = 1'b0, prev_ready = 1'b0;
  logic [7:0] prev_data = '0;

  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (gen_start) gs_cnt++;
      if (prev_valid && !prev_ready) begin
        chk("hold_valid", out_if.valid, 1);
        chk("hold_data", out_if.data, prev_data);
      end
      if (out_if.valid && out_if.ready) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'(sb.size()), 1);
        end else begin
          e = sb.pop_front();
          chk("out_data", out_if.data, e[7:0]);
          chk("out_last", out_if.last, e[8]);
        end
      end
      prev_valid = out_if.valid;
      prev_ready = out_if.ready;
      prev_data  = out_if.data;
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic q8_t xor_ref(input q8_t d);
    q8_t r;
    foreach (d[k]) r.push_back(d[k] ^ ref_ks[SKIP + k]);
    return r;
  endfunction

  task automatic feed(input q8_t din, input q8_t exp, input bit mark_last, input bit mid_start);
    bit acc;
    for (int k = 0; k < din.size(); k++) begin
      in_if.valid = 1'b1;
      in_if.data  = din[k];
      in_if.last  = mark_last && (k == din.size() - 1);
      if (mid_start && k == din.size() / 2) start = 1'b1;
      acc = 1'b0;
      for (int t = 0; t < 400 && !acc; t++) begin
        @(negedge clk);
        acc = in_if.ready;
        if (acc) sb.push_back({in_if.last, exp[k]});
        @(posedge clk);
        #1;
        start = 1'b0;
      end
      chk("in_accept", acc, 1);
    end
    in_if.valid = 1'b0;
    in_if.last  = 1'b0;
  endtask

  task automatic run_msg(input string name, input q8_t din, input q8_t exp, input bit mid_start);
    int  gs0;
    bit  seen;
    gs0 = gs_cnt;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    feed(din, exp, 1'b1, mid_start);
    seen = 1'b0;
    for (int t = 0; t < 1000 && !seen; t++) begin
      @(negedge clk);
      seen = done;
    end
    chk({name, "_done"}, seen, 1);
    chk({name, "_busy_idle"}, busy, 0);
    chk({name, "_sb_empty"}, 32'(sb.size()), 0);
    chk({name, "_inflight_zero"}, 32'(pend.size()), 0);
    @(negedge clk);
    chk({name, "_done_pulse"}, done, 0);
    chk({name, "_gen_start_once"}, 32'(gs_cnt - gs0), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_done"}, done, 0);
    chk({name, "_gen_start"}, gen_start, 0);
    chk({name, "_ks_req"}, ks_req, 0);
    chk({name, "_in_ready"}, in_if.ready, 0);
    chk({name, "_out_valid"}, out_if.valid, 0);
    chk({name, "_out_data"}, out_if.data, 0);
    chk({name, "_ks_err"}, ks_err, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    q8_t pt, ct, din, exp;
    logic [7:0] kb;
    in_if.valid = 1'b0;
    in_if.data  = '0;
    in_if.last  = 1'b0;
    m_ksa();
    for (int i = 0; i < 32; i++) begin
      m_prga(kb);
      ref_ks[i] = kb;
    end
    pt = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
    ct = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

`ifdef RC4_XOR_DROP_EN
    din = '{8'h00, 8'h00};
    run_msg("drop", din, xor_ref(din), 1'b0);
`else
    run_msg("encrypt", pt, ct, 1'b0);
    run_msg("decrypt", ct, pt, 1'b0);
`endif

    bp_mode = 1'b1;
    run_msg("backpressure", pt, xor_ref(pt), 1'b1);
    bp_mode = 1'b0;
    @(posedge clk);
    #1;
    chk("max_inflight_le_depth", 32'(max_inflight <= FIFO_DEPTH), 1);

    spur_valid = 1'b1;
    @(posedge clk);
    #1;
    spur_valid = 1'b0;
    @(negedge clk);
    chk("spur_ks_err", ks_err, 1);
    chk("spur_out_valid", out_if.valid, 0);
    chk("spur_busy", busy, 0);
    @(posedge clk);
    #1;

    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    din = '{pt[0], pt[1], pt[2]};
    feed(din, xor_ref(din), 1'b0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("abort");
    sb.delete();
    @(posedge clk);
    #1;

    run_msg("restart", pt, xor_ref(pt), 1'b0);

    din = '{8'h50};
`ifdef RC4_XOR_DROP_EN
    exp = xor_ref(din);
`else
    exp = '{8'hBB};
`endif
    run_msg("single", din, exp, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rc4_xor_stream.md
Name: rc4_xor_stream

Overview:
- Consumer end of the RC4 keystream interface.
- Starts the keystream generator and waits for key scheduling to finish.
- Prefetches keystream bytes into a small FIFO and XORs them with a byte-wide data stream.
- The same block encrypts and decrypts. It sits between the host data path and the rc4 generator core.

Parameters:
- FIFO_DEPTH, 4, keystream prefetch entries; power of two, at least 2.
- DROP_N, 256, leading keystream bytes discarded when RC4_XOR_DROP_EN is defined.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset: synchronous, active-low. Clock is clk.
- start  in  1  one-cycle pulse; begins a message. Ignored unless in IDLE.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the last output byte is accepted.
- gen_start  out  1  one-cycle pulse to the generator.
- gen_ready  in  1  level; generator has finished key scheduling.
- ks_req  out  1  one-cycle request for one keystream byte.
- ks_valid  in  1  one-cycle pulse; ks_data is valid.
- ks_data  in  8  keystream byte.
- in_valid  in  1  input byte valid.
- in_ready  out  1  input byte accepted when in_valid && in_ready.
- in_data  in  8  plaintext or ciphertext byte.
- in_last  in  1  marks the final byte of the message.
- out_valid  out  1  output byte valid.
- out_ready  in  1  downstream accepts.
- out_data  out  8  in_data XOR keystream byte.
- ks_err  out  1  sticky; set by an unexpected ks_valid.

Behaviour:
- Reset values: busy=0, done=0, gen_start=0, ks_req=0, in_ready=0, out_valid=0, out_data=0, ks_err=0. FIFO empty, outstanding count=0, state=IDLE.
- IDLE -> INIT on start. In the INIT entry cycle, gen_start is pulsed once and the FIFO plus counters are cleared. start in any other state is ignored.
- INIT -> DROP when gen_ready=1 and the macro is defined; otherwise INIT -> RUN. gen_ready already high on the INIT entry cycle is still honoured on the next cycle.
- Request rule (DROP and RUN): ks_req=1 when outstanding + fifo_count < FIFO_DEPTH and last_seen=0. Outstanding is incremented on ks_req and decremented on ks_valid. Simultaneous request and response nets to zero change.
- Counter widths: $clog2(FIFO_DEPTH)+1 bits; never wrap.
- DROP: each ks_valid byte is discarded, not written to the FIFO. Leaves for RUN once DROP_N bytes are discarded, i.e. drop counter reaches DROP_N-1 on a ks_valid. Requests outstanding at exit land in the FIFO.
- RUN: a ks_valid byte is written to the FIFO tail.
- RUN: in_ready = fifo_nonempty && (!out_valid || out_ready) && !last_seen.
- RUN: on in_valid && in_ready, pop the FIFO head. The registered out_data = in_data ^ head and out_valid=1 on the next edge; latency is 1 cycle.
- RUN: out_valid holds with out_data stable until out_ready.
- RUN: a FIFO write and pop in the same cycle keeps fifo_count unchanged.
- in_last accepted: last_seen=1, no new requests, and the state moves to DRAIN.
- DRAIN: wait until outstanding=0 and the final output byte is accepted. Then discard remaining FIFO contents, pulse done, and go to IDLE.
- A new message always re-runs gen_start, so no keystream carries over between messages.
- ks_valid while outstanding=0 sets ks_err (sticky until reset) and the byte is discarded.
- rst_n low in any state aborts at once. All registers return to reset values and partial output is lost.

Optional Feature:
- Macro RC4_XOR_DROP_EN.
- Defined: DROP state present; the first DROP_N keystream bytes after gen_ready are discarded (RC4-drop[n]).
- Undefined: DROP state and drop counter are absent, INIT goes directly to RUN, and DROP_N is unused.

Decomposition:
- Package rc4_pkg:
  - state enum {IDLE, INIT, DROP, RUN, DRAIN}
  - localparam KS_W=8
  - shared byte typedef
- One sub-module: rc4_ks_fifo, a synchronous FIFO of FIFO_DEPTH x 8 with push, pop, count, empty and full.

Test Plan (bench uses a behavioural RC4 generator model with random 0-3 cycle response delay, macro undefined unless noted):
- Key "Key", input "Plaintext" (9 bytes, in_last on 't'), out_ready=1 -> out_data BB F3 16 E8 D9 40 AF 0A D3, then done pulse, busy=0.
- Decrypt: feed BB F3 16 E8 D9 40 AF 0A D3 with key "Key" -> 50 6C 61 69 6E 74 65 78 74.
- Backpressure: out_ready toggled 1 cycle on, 3 off on the "Plaintext" case -> identical bytes, out_data stable while stalled, never more than FIFO_DEPTH requests in flight.
- Flow and errors: start pulsed mid-message -> ignored. Spurious ks_valid in IDLE -> ks_err=1, outputs unaffected. rst_n low mid-RUN -> all outputs at reset values next cycle. A following start produces the correct stream from byte 0.
- RC4_XOR_DROP_EN with DROP_N=4, key "Key", input 00 00 -> out_data equals generator bytes 5 and 6 (keystream bytes 4-5 zero-indexed).
- Single-byte message with in_last on the first byte, input 0x50, key "Key" -> out 0xBB, done pulse; any keystream still outstanding is absorbed before IDLE.
